// File: rtl/load_store_unit.sv
// ============================================================================
// Module  : load_store_unit
// Brief   : MEM-stage load/store unit with sub-word loads and RMW sub-word
//           stores. Optional macro MISALIGN_TRAP_EN traps misaligned accesses.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_BITS   = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_load,
    input  logic                  req_store,
    input  logic [2:0]            req_funct3,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [REG_BITS-1:0]   req_rd,
    output logic                  stall,
    output logic [DATA_WIDTH-1:0] dm_address,
    output logic [DATA_WIDTH-1:0] dm_wdata,
    output logic                  dm_memread,
    output logic                  dm_memwrite,
    input  logic [DATA_WIDTH-1:0] dm_rdata,
    output logic                  wb_valid,
    output logic [REG_BITS-1:0]   wb_rd,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic                  misalign
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   rmw_addr_q, rmw_addr_d;
    logic [DATA_WIDTH-1:0]   rmw_data_q, rmw_data_d;
    logic                    wb_valid_q, wb_valid_d;
    logic [REG_BITS-1:0]     wb_rd_q, wb_rd_d;
    logic [DATA_WIDTH-1:0]   wb_data_q, wb_data_d;
    logic                    misalign_q, misalign_d;

    logic                    acc_store, acc_load;
    logic                    is_byte, is_half, is_word, is_unsigned;
    logic                    trap;
    logic [1:0]              lane_off;
    logic [4:0]              lane_sh;
    logic [DATA_WIDTH-1:0]   aligned_addr, shifted, lane_mask, merged, load_ext;

    assign acc_store = req_valid & req_store;
    assign acc_load  = req_valid & req_load & ~req_store;

    // BU/HU codes only exist for loads; stores with funct3[2] set fall to word.
    assign is_byte     = (req_funct3 == 3'b000) | (acc_load & (req_funct3 == 3'b100));
    assign is_half     = (req_funct3 == 3'b001) | (acc_load & (req_funct3 == 3'b101));
    assign is_word     = ~is_byte & ~is_half;
    assign is_unsigned = req_funct3[2];

`ifdef MISALIGN_TRAP_EN
    assign trap = (is_half & req_addr[0]) | (is_word & (req_addr[1:0] != 2'b00));
`else
    assign trap = 1'b0;
`endif

    // Lane offset with forced alignment; a trapped access never uses it.
    assign lane_off     = is_byte ? req_addr[1:0] : (is_half ? {req_addr[1], 1'b0} : 2'b00);
    assign lane_sh      = {lane_off, 3'b000};
    assign aligned_addr = {req_addr[DATA_WIDTH-1:2], 2'b00};
    assign shifted      = dm_rdata >> lane_sh;
    assign lane_mask    = is_byte ? 32'h0000_00FF : 32'h0000_FFFF;
    assign merged       = (dm_rdata & ~(lane_mask << lane_sh)) | ((req_wdata & lane_mask) << lane_sh);

    always_comb begin
        load_ext = dm_rdata;
        if (is_byte)
            load_ext = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
        else if (is_half)
            load_ext = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
    end

    always_comb begin
        state_d     = state_q;
        rmw_addr_d  = rmw_addr_q;
        rmw_data_d  = rmw_data_q;
        wb_valid_d  = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        misalign_d  = 1'b0;
        dm_address  = '0;
        dm_wdata    = '0;
        dm_memread  = 1'b0;
        dm_memwrite = 1'b0;
        case (state_q)
            IDLE: begin
                if (acc_store) begin
                    if (trap) begin
                        misalign_d = 1'b1;
                    end else if (is_word) begin
                        dm_memwrite = 1'b1;
                        dm_address  = aligned_addr;
                        dm_wdata    = req_wdata;
                    end else begin
                        dm_memread = 1'b1;
                        dm_address = aligned_addr;
                        rmw_addr_d = aligned_addr;
                        rmw_data_d = merged;
                        state_d    = RMW_WR;
                    end
                end else if (acc_load) begin
                    if (trap) begin
                        misalign_d = 1'b1;
                    end else begin
                        dm_memread = 1'b1;
                        dm_address = aligned_addr;
                        wb_valid_d = 1'b1;
                        wb_rd_d    = req_rd;
                        wb_data_d  = load_ext;
                    end
                end
            end
            RMW_WR: begin
                dm_memwrite = 1'b1;
                dm_address  = rmw_addr_q;
                dm_wdata    = rmw_data_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rmw_addr_q <= '0;
            rmw_data_q <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rmw_addr_q <= rmw_addr_d;
            rmw_data_q <= rmw_data_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            misalign_q <= misalign_d;
        end
    end

    assign stall    = (state_q == RMW_WR);
    assign wb_valid = wb_valid_q;
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;
    assign misalign = misalign_q;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module  : tb_load_store_unit
// Brief   : Directed bench for load_store_unit with a word-addressed memory.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_load, req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        stall;
    logic [31:0] dm_address, dm_wdata, dm_rdata;
    logic        dm_memread, dm_memwrite;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misalign;

    logic        mem_init;
    logic [31:0] mem [0:15];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    load_store_unit #(.DATA_WIDTH(32), .REG_BITS(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_load   (req_load),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .stall      (stall),
        .dm_address (dm_address),
        .dm_wdata   (dm_wdata),
        .dm_memread (dm_memread),
        .dm_memwrite(dm_memwrite),
        .dm_rdata   (dm_rdata),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .misalign   (misalign)
    );

    // Word-addressed data memory: combinational read, write on the clock edge.
    assign dm_rdata = mem[dm_address[5:2]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[1] <= 32'h8899AABB;
        end else if (dm_memwrite) begin
            mem[dm_address[5:2]] <= dm_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
        req_valid  = v;
        req_load   = ld;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        req_rd     = rd;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle load: checks the memory address and the registered result.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [4:0] rd, input logic [31:0] exp_addr, input logic [31:0] exp_data);
        drive(1'b1, 1'b1, 1'b0, f3, a, 32'h0, rd);
        #1;
        check({tag, "_addr"}, dm_address, exp_addr);
        step();
        check({tag, "_wbv"}, {31'b0, wb_valid}, 32'd1);
        check({tag, "_data"}, wb_data, exp_data);
        check({tag, "_rd"}, {27'b0, wb_rd}, {27'b0, rd});
        idle();
    endtask

    initial begin
        idle();
        rst      = 1'b1;
        mem_init = 1'b1;
        step();
        step();
        rst      = 1'b0;
        mem_init = 1'b0;

        check("rst_stall", {31'b0, stall}, 32'd0);
        check("rst_wbv",   {31'b0, wb_valid}, 32'd0);
        check("rst_wbdata", wb_data, 32'd0);
        check("rst_misal", {31'b0, misalign}, 32'd0);
        check("rst_dmrd",  {31'b0, dm_memread}, 32'd0);
        check("rst_dmwr",  {31'b0, dm_memwrite}, 32'd0);
        check("rst_dmaddr", dm_address, 32'd0);

        do_load("lb5",   3'b000, 32'h5, 5'd3,  32'h4, 32'hFFFFFFAA);
        step();
        check("wbv_pulse", {31'b0, wb_valid}, 32'd0);
        do_load("lhu6",  3'b101, 32'h6, 5'd7,  32'h4, 32'h00008899);
        do_load("lh6",   3'b001, 32'h6, 5'd8,  32'h4, 32'hFFFF8899);
        do_load("lbu7",  3'b100, 32'h7, 5'd9,  32'h4, 32'h00000088);
        do_load("lb4",   3'b000, 32'h4, 5'd10, 32'h4, 32'hFFFFFFBB);
        do_load("lw4",   3'b010, 32'h4, 5'd11, 32'h4, 32'h8899AABB);
        do_load("lf011", 3'b011, 32'h4, 5'd12, 32'h4, 32'h8899AABB);

        drive(1'b0, 1'b1, 1'b0, 3'b010, 32'h4, 32'h0, 5'd1);
        #1;
        check("novalid_rd", {31'b0, dm_memread}, 32'd0);
        step();
        check("novalid_wbv", {31'b0, wb_valid}, 32'd0);

        // SB: read phase, then a stalled write phase with the next load held.
        drive(1'b1, 1'b0, 1'b1, 3'b000, 32'h4, 32'h00000012, 5'd0);
        #1;
        check("sb_rd",    {31'b0, dm_memread}, 32'd1);
        check("sb_nostall", {31'b0, stall}, 32'd0);
        step();
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h4, 32'h0, 5'd5);
        check("sb_stall", {31'b0, stall}, 32'd1);
        check("sb_wr",    {31'b0, dm_memwrite}, 32'd1);
        check("sb_wrrd",  {31'b0, dm_memread}, 32'd0);
        check("sb_wdata", dm_wdata, 32'h8899AA12);
        check("sb_waddr", dm_address, 32'h4);
        check("sb_wbv",   {31'b0, wb_valid}, 32'd0);
        step();
        check("sb_mem",   mem[1], 32'h8899AA12);
        check("sb_unstall", {31'b0, stall}, 32'd0);
        check("held_rd",  {31'b0, dm_memread}, 32'd1);
        check("held_wbv0", {31'b0, wb_valid}, 32'd0);
        step();
        idle();
        check("held_wbv", {31'b0, wb_valid}, 32'd1);
        check("held_data", wb_data, 32'h8899AA12);
        check("held_wbrd", {27'b0, wb_rd}, 32'd5);

        // SW then LW on the following cycle; load+store both high means store.
        drive(1'b1, 1'b1, 1'b1, 3'b010, 32'h8, 32'hDEADBEEF, 5'd2);
        #1;
        check("sw_wr",    {31'b0, dm_memwrite}, 32'd1);
        check("sw_wdata", dm_wdata, 32'hDEADBEEF);
        check("sw_rd",    {31'b0, dm_memread}, 32'd0);
        step();
        check("sw_wbv",   {31'b0, wb_valid}, 32'd0);
        check("sw_stall", {31'b0, stall}, 32'd0);
        do_load("lw8", 3'b010, 32'h8, 5'd4, 32'h8, 32'hDEADBEEF);

        // SH on the upper half: lanes 2..3 replaced.
        drive(1'b1, 1'b0, 1'b1, 3'b001, 32'h6, 32'hFFFF1234, 5'd0);
        step();
        idle();
        check("sh6_wdata", dm_wdata, 32'h1234AA12);
        step();
        check("sh6_mem", mem[1], 32'h1234AA12);

        // Reset during the write phase of an SH must suppress the write.
        drive(1'b1, 1'b0, 1'b1, 3'b001, 32'h4, 32'h00005555, 5'd0);
        step();
        idle();
        check("rstrmw_stall", {31'b0, stall}, 32'd1);
        rst = 1'b1;
        #1;
        check("rstrmw_wr",    {31'b0, dm_memwrite}, 32'd0);
        check("rstrmw_stall0", {31'b0, stall}, 32'd0);
        check("rstrmw_wbdata", wb_data, 32'd0);
        check("rstrmw_wbrd",  {27'b0, wb_rd}, 32'd0);
        step();
        rst = 1'b0;
        step();
        check("rstrmw_mem",   mem[1], 32'h1234AA12);
        check("rstrmw_dmaddr", dm_address, 32'd0);

`ifdef MISALIGN_TRAP_EN
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h6, 32'h0, 5'd6);
        #1;
        check("mis_rd", {31'b0, dm_memread}, 32'd0);
        step();
        idle();
        check("mis_pulse", {31'b0, misalign}, 32'd1);
        check("mis_wbv",   {31'b0, wb_valid}, 32'd0);
        check("mis_stall", {31'b0, stall}, 32'd0);
        step();
        check("mis_end",   {31'b0, misalign}, 32'd0);
`else
        do_load("lw6", 3'b010, 32'h6, 5'd6, 32'h4, 32'h1234AA12);
        check("mis_off", {31'b0, misalign}, 32'd0);
        do_load("lh5", 3'b001, 32'h5, 5'd6, 32'h4, 32'hFFFFAA12);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
